// File: rtl/sw_debounce_if.sv
// Switch bundle between the board pins and the debouncer: raw levels in,
// debounced level plus edge pulses out.
interface sw_debounce_if #(
  parameter int N_SW = 2
);
  logic [N_SW-1:0] sw;
  logic [N_SW-1:0] sw_db;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;

  modport master (output sw, input sw_db, sw_rise, sw_fall);
  modport slave  (input sw, output sw_db, sw_rise, sw_fall);
endinterface

// File: rtl/sw_debounce.sv
// Per-channel switch debouncer: 2-flop synchronizer, then a STABLE/PENDING
// FSM that accepts a new level only after DB_CYCLES consecutive clk_125 cycles.
module sw_debounce_lane #(
  parameter int DB_CYCLES = 1250000
) (
  input  logic clk_125,
  input  logic rst,
  input  logic sw,
  output logic sw_db,
  output logic sw_rise,
  output logic sw_fall
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic {STABLE, PENDING} state_t;

  state_t        state;
  logic          s1, s2;
  logic [CW-1:0] cnt;

  // state always mirrors (s2 != sw_db); it is computed one edge ahead from s1.
  always_ff @(posedge clk_125) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      sw_db   <= 1'b0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      cnt     <= '0;
      state   <= STABLE;
    end else begin
      s1      <= sw;
      s2      <= s1;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      case (state)
        STABLE: begin
          cnt   <= '0;
          state <= (s1 != sw_db) ? PENDING : STABLE;
        end
        PENDING: begin
          if (cnt == CNT_LAST) begin
            sw_db   <= s2;
            sw_rise <= s2;
            sw_fall <= ~s2;
            cnt     <= '0;
            state   <= (s1 != s2) ? PENDING : STABLE;
          end else if (s1 == sw_db) begin
            // input is about to fall back to the accepted level: glitch dropped
            cnt   <= '0;
            state <= STABLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= STABLE;
        end
      endcase
    end
  end
endmodule

module sw_debounce #(
  parameter int N_SW      = 2,
  parameter int DB_CYCLES = 1250000
) (
  input  logic              clk_125,
  input  logic              rst,
  sw_debounce_if.slave      bus
);
  generate
    if (DB_CYCLES < 1) begin : g_bad_param
      $error("sw_debounce: DB_CYCLES must be >= 1");
    end
  endgenerate

  logic [N_SW-1:0] db_w, rise_w, fall_w;

  generate
    for (genvar i = 0; i < N_SW; i++) begin : g_lane
      sw_debounce_lane #(.DB_CYCLES(DB_CYCLES)) u_lane (
        .clk_125 (clk_125),
        .rst     (rst),
        .sw      (bus.sw[i]),
        .sw_db   (db_w[i]),
        .sw_rise (rise_w[i]),
        .sw_fall (fall_w[i])
      );
    end
  endgenerate

  assign bus.sw_db   = db_w;
  assign bus.sw_rise = rise_w;
  assign bus.sw_fall = fall_w;
endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter N_SW, default 2: number of independent switch channels.
REQ-002 SHALL have parameter DB_CYCLES, default 1250000: consecutive clk_125 cycles a changed input must persist before acceptance (10 ms at 125 MHz).
REQ-003 SHALL have port clk_125  input  1: 125 MHz PL clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port sw  input  N_SW: raw asynchronous board switches (sw[0]=SW0, sw[1]=SW1).
REQ-006 SHALL have port sw_db  output  N_SW: debounced switch level, registered, feeds the downstream 3-stage LED pipeline.
REQ-007 SHALL have port sw_rise  output  N_SW: one-cycle pulse on an accepted 0->1 change of sw_db.
REQ-008 SHALL have port sw_fall  output  N_SW: one-cycle pulse on an accepted 1->0 change of sw_db.

Function
REQ-009 SHALL pass each sw bit through a 2-flop synchronizer (s1, s2) before any other use; no logic between the two flops.
REQ-010 SHALL keep per channel a counter of width clog2(DB_CYCLES+1) and a two-state FSM: STABLE (s2 == sw_db) and PENDING (s2 != sw_db).
REQ-011 SHALL, in STABLE, hold the counter at 0 and hold sw_db.
REQ-012 SHALL, in PENDING with counter < DB_CYCLES-1, increment the counter by 1 per cycle.
REQ-013 SHALL, in PENDING with counter == DB_CYCLES-1, load sw_db with s2, clear the counter, and return to STABLE on the same edge.
REQ-014 SHALL, when s2 returns equal to sw_db before acceptance, clear the counter to 0 on that edge and leave sw_db unchanged (glitch rejected, no pulse).
REQ-015 SHALL assert sw_rise[i] or sw_fall[i] for exactly one cycle, the same cycle sw_db[i] first shows the new value; never both at once on one channel.
REQ-016 SHALL give latency from the edge that first samples a new stable sw value into s1 to sw_db changing of exactly DB_CYCLES+2 rising edges (that edge included).
REQ-017 SHALL treat channels fully independently; simultaneous changes on several channels SHALL each be accepted on their own schedule, pulses in the same cycle if timing coincides.
REQ-018 SHALL never wrap the counter; it shall not exceed DB_CYCLES-1.
REQ-019 SHALL support DB_CYCLES >= 1; DB_CYCLES = 1 gives latency 3 edges; values < 1 SHALL be rejected at elaboration.
REQ-020 SHALL register all outputs; no combinational path from sw to any output.

Reset
REQ-021 SHALL, on any rising edge with rst=1, set s1, s2, sw_db, sw_rise, sw_fall and all counters to 0 and all FSMs to STABLE.
REQ-022 SHALL, with rst held, keep all outputs at 0 regardless of sw.
REQ-023 SHALL, on rst asserted mid-PENDING, discard the partial count; counting restarts from 0 after release.
REQ-024 SHALL, if a switch is at 1 when rst is released, accept it like any other change: sw_db=1 and one sw_rise pulse DB_CYCLES+2 edges after the first post-reset edge.

Verification (DB_CYCLES=4, N_SW=2)
REQ-025 SHALL cover: rst=1 for 3 cycles with sw=2'b11 -> sw_db, sw_rise, sw_fall all 0 throughout.
REQ-026 SHALL cover: from reset-idle, sw[0] 0->1 before edge E0 and held -> sw_db[0]=1 after edge E0+5 (6 edges), sw_rise[0]=1 for that one cycle only, sw_fall=0, sw_db[1]=0.
REQ-027 SHALL cover: sw[1] high for 3 cycles then low -> sw_db[1] stays 0, no pulses on either output.
REQ-028 SHALL cover: sw[0] toggles 1,0,1,0,1 on consecutive cycles then held at 1 -> sw_db[0] rises exactly 6 edges after the final toggle is sampled, single sw_rise[0] pulse.
REQ-029 SHALL cover: both channels stable at 1, sw 2'b11->2'b00 on one edge -> sw_fall=2'b11 in the same single cycle, sw_db=2'b00 from that cycle.
REQ-030 SHALL cover: sw[0] 0->1, rst pulsed for 1 cycle when counter=2, sw held at 1 -> outputs 0 after reset edge; sw_db[0]=1 and one sw_rise[0] 6 edges after the first post-reset edge.
